// File: rtl/decode_stage.sv
// Registered instruction decode stage for the 9-bit core with a sticky halt state.
// Define DECODE_HAZARD_EN to build in load-use stall insertion (LU_STALL bubbles).
module decode_stage #(
  parameter int JW       = 8,
  parameter int LU_STALL = 1
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [8:0]    mach_code,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    Aluop,
  output logic [2:0]    Ra,
  output logic [2:0]    Rb,
  output logic [2:0]    Wd,
  output logic          WenR,
  output logic          WenD,
  output logic          Ldr,
  output logic          Str,
  output logic          Jump,
  output logic          Halt,
  output logic [JW-1:0] Jptr,
  output logic          halted
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

  logic [2:0]    op;
  logic [2:0]    dec_aluop, dec_ra, dec_rb, dec_wd;
  logic          dec_wenr, dec_wend, dec_ldr, dec_str, dec_jump, dec_halt;
  logic [JW-1:0] dec_jptr;

  logic          accept;
  logic          stall;

  logic [0:0]    state_q, state_d;
  logic          out_valid_q, out_valid_d;
  logic [2:0]    aluop_q, aluop_d, ra_q, ra_d, rb_q, rb_d, wd_q, wd_d;
  logic          wenr_q, wenr_d, wend_q, wend_d, ldr_q, ldr_d;
  logic          str_q, str_d, jump_q, jump_d, halt_q, halt_d;
  logic [JW-1:0] jptr_q, jptr_d;

  assign op = mach_code[8:6];

  always_comb begin
    dec_aluop = '0;
    dec_ra    = '0;
    dec_rb    = '0;
    dec_wd    = '0;
    dec_wenr  = 1'b0;
    dec_wend  = 1'b0;
    dec_ldr   = 1'b0;
    dec_str   = 1'b0;
    dec_jump  = 1'b0;
    dec_halt  = 1'b0;
    dec_jptr  = '0;
    case (op)
      3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
        dec_aluop = op;
        dec_ra    = mach_code[5:3];
        dec_wd    = mach_code[5:3];
        dec_rb    = mach_code[2:0];
        dec_wenr  = 1'b1;
      end
      3'b101: begin
        dec_wd   = mach_code[5:3];
        dec_rb   = mach_code[2:0];
        dec_ldr  = 1'b1;
        dec_wenr = 1'b1;
      end
      3'b110: begin
        dec_ra   = mach_code[5:3];
        dec_rb   = mach_code[2:0];
        dec_str  = 1'b1;
        dec_wend = 1'b1;
      end
      default: begin
        // 9'h1FF has bit 5 set, so HALT never collides with the jump encoding
        if (mach_code == 9'h1FF) begin
          dec_halt = 1'b1;
        end else if (!mach_code[5]) begin
          dec_jump      = 1'b1;
          dec_jptr[4:0] = mach_code[4:0];
        end
      end
    endcase
  end

  assign in_ready = Reset && (state_q == ST_RUN) && (!out_valid_q || out_ready) && !stall;
  assign accept   = in_valid && in_ready;

`ifdef DECODE_HAZARD_EN
  logic [1:0] cnt_q, cnt_d;
  logic [2:0] ld_reg_q, ld_reg_d;
  logic       rd_a, rd_b;

  // Only the most recently accepted LDR is tracked; any other accept clears it.
  always_comb begin
    rd_a  = (op <= 3'b100) || (op == 3'b110);
    rd_b  = (op != 3'b111);
    stall = (cnt_q != 2'd0) &&
            ((rd_a && (mach_code[5:3] == ld_reg_q)) ||
             (rd_b && (mach_code[2:0] == ld_reg_q)));
    cnt_d    = cnt_q;
    ld_reg_d = ld_reg_q;
    if (accept) begin
      if (dec_ldr) begin
        cnt_d    = 2'(LU_STALL);
        ld_reg_d = dec_wd;
      end else begin
        cnt_d = 2'd0;
      end
    end else if (cnt_q != 2'd0) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      cnt_q    <= 2'd0;
      ld_reg_q <= 3'd0;
    end else begin
      cnt_q    <= cnt_d;
      ld_reg_q <= ld_reg_d;
    end
  end
`else
  assign stall = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    aluop_d     = aluop_q;
    ra_d        = ra_q;
    rb_d        = rb_q;
    wd_d        = wd_q;
    wenr_d      = wenr_q;
    wend_d      = wend_q;
    ldr_d       = ldr_q;
    str_d       = str_q;
    jump_d      = jump_q;
    halt_d      = halt_q;
    jptr_d      = jptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      aluop_d     = dec_aluop;
      ra_d        = dec_ra;
      rb_d        = dec_rb;
      wd_d        = dec_wd;
      wenr_d      = dec_wenr;
      wend_d      = dec_wend;
      ldr_d       = dec_ldr;
      str_d       = dec_str;
      jump_d      = dec_jump;
      halt_d      = dec_halt;
      jptr_d      = dec_jptr;
      if (dec_halt) state_d = ST_HALTED;
    end else if (out_ready) begin
      // Drained with nothing new: present an all-zero bubble.
      out_valid_d = 1'b0;
      aluop_d     = '0;
      ra_d        = '0;
      rb_d        = '0;
      wd_d        = '0;
      wenr_d      = 1'b0;
      wend_d      = 1'b0;
      ldr_d       = 1'b0;
      str_d       = 1'b0;
      jump_d      = 1'b0;
      halt_d      = 1'b0;
      jptr_d      = '0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q     <= ST_RUN;
      out_valid_q <= 1'b0;
      aluop_q     <= '0;
      ra_q        <= '0;
      rb_q        <= '0;
      wd_q        <= '0;
      wenr_q      <= 1'b0;
      wend_q      <= 1'b0;
      ldr_q       <= 1'b0;
      str_q       <= 1'b0;
      jump_q      <= 1'b0;
      halt_q      <= 1'b0;
      jptr_q      <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      aluop_q     <= aluop_d;
      ra_q        <= ra_d;
      rb_q        <= rb_d;
      wd_q        <= wd_d;
      wenr_q      <= wenr_d;
      wend_q      <= wend_d;
      ldr_q       <= ldr_d;
      str_q       <= str_d;
      jump_q      <= jump_d;
      halt_q      <= halt_d;
      jptr_q      <= jptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign Aluop     = aluop_q;
  assign Ra        = ra_q;
  assign Rb        = rb_q;
  assign Wd        = wd_q;
  assign WenR      = wenr_q;
  assign WenD      = wend_q;
  assign Ldr       = ldr_q;
  assign Str       = str_q;
  assign Jump      = jump_q;
  assign Halt      = halt_q;
  assign Jptr      = jptr_q;
  assign halted    = (state_q == ST_HALTED);

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (JW=8, LU_STALL=1); expectations follow
// DECODE_HAZARD_EN so the same bench covers both builds.
module tb_decode_stage;

  logic       Clk = 1'b0;
  logic       Reset, in_valid, in_ready, out_valid, out_ready;
  logic [8:0] mach_code;
  logic [2:0] Aluop, Ra, Rb, Wd;
  logic       WenR, WenD, Ldr, Str, Jump, Halt, halted;
  logic [7:0] Jptr;

  int checks = 0;
  int errors = 0;

  localparam logic [8:0] W_ALU  = 9'b001_010_011;
  localparam logic [8:0] W_JMP  = 9'b111_0_10101;
  localparam logic [8:0] W_LDR  = 9'b101_100_001;
  localparam logic [8:0] W_DEP  = 9'b000_100_010;
  localparam logic [8:0] W_STR  = 9'b110_011_101;
  localparam logic [8:0] W_HALT = 9'h1FF;

`ifdef DECODE_HAZARD_EN
  localparam bit HAZ = 1'b1;
`else
  localparam bit HAZ = 1'b0;
`endif

  decode_stage #(.JW(8), .LU_STALL(1)) dut (
    .Clk(Clk), .Reset(Reset), .in_valid(in_valid), .in_ready(in_ready),
    .mach_code(mach_code), .out_valid(out_valid), .out_ready(out_ready),
    .Aluop(Aluop), .Ra(Ra), .Rb(Rb), .Wd(Wd), .WenR(WenR), .WenD(WenD),
    .Ldr(Ldr), .Str(Str), .Jump(Jump), .Halt(Halt), .Jptr(Jptr), .halted(halted)
  );

  always #5 Clk = ~Clk;

  // {out_valid, Aluop, Ra, Rb, Wd, WenR, WenD, Ldr, Str, Jump, Halt, Jptr}
  logic [26:0] obs;
  assign obs = {out_valid, Aluop, Ra, Rb, Wd, WenR, WenD, Ldr, Str, Jump, Halt, Jptr};

  function automatic logic [26:0] ob(input logic v, input logic [2:0] a, input logic [2:0] ra,
                                     input logic [2:0] rb, input logic [2:0] wd,
                                     input logic [5:0] s, input logic [7:0] jp);
    return {v, a, ra, rb, wd, s, jp};
  endfunction

  localparam logic [26:0] E_ZERO = 27'd0;
  // strobe order: WenR WenD Ldr Str Jump Halt
  logic [26:0] e_alu, e_jmp, e_ldr, e_dep, e_str, e_halt;

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    e_alu  = ob(1'b1, 3'd1, 3'd2, 3'd3, 3'd2, 6'b100000, 8'd0);
    e_jmp  = ob(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 6'b000010, 8'd21);
    e_ldr  = ob(1'b1, 3'd0, 3'd0, 3'd1, 3'd4, 6'b101000, 8'd0);
    e_dep  = ob(1'b1, 3'd0, 3'd4, 3'd2, 3'd4, 6'b100000, 8'd0);
    e_str  = ob(1'b1, 3'd0, 3'd3, 3'd5, 3'd0, 6'b010100, 8'd0);
    e_halt = ob(1'b1, 3'd0, 3'd0, 3'd0, 3'd0, 6'b000001, 8'd0);

    Reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; mach_code = 9'd0;
    tick(); tick();
    check("reset_outputs", 32'(obs), 32'(E_ZERO));
    check("reset_halted", 32'(halted), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd0);
    Reset = 1'b1; #1;
    check("run_in_ready", 32'(in_ready), 32'd1);

    // ALU decode
    mach_code = W_ALU; in_valid = 1'b1; #1;
    check("alu_in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("alu_out", 32'(obs), 32'(e_alu));
    tick();
    check("alu_drain_bubble", 32'(obs), 32'(E_ZERO));

    // Jump
    mach_code = W_JMP; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("jump_out", 32'(obs), 32'(e_jmp));
    tick();

    // Load-use
    mach_code = W_LDR; in_valid = 1'b1;
    tick();
    check("ldr_out", 32'(obs), 32'(e_ldr));
    mach_code = W_DEP; #1;
    check("lu_in_ready_first", 32'(in_ready), HAZ ? 32'd0 : 32'd1);
    tick();
    if (HAZ) begin
      check("lu_bubble", 32'(obs), 32'(E_ZERO));
      check("lu_in_ready_second", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    check("lu_dep_out", 32'(obs), 32'(e_dep));
    tick();
    check("lu_drain", 32'(obs), 32'(E_ZERO));

    // Backpressure on a store
    mach_code = W_STR; in_valid = 1'b1;
    tick();
    check("str_out", 32'(obs), 32'(e_str));
    out_ready = 1'b0; mach_code = W_ALU;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp_hold_%0d", i), 32'(obs), 32'(e_str));
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    check("bp_drain", 32'(obs), 32'(E_ZERO));

    // Halt is sticky until reset
    mach_code = W_HALT; in_valid = 1'b1;
    tick();
    check("halt_out", 32'(obs), 32'(e_halt));
    check("halt_halted", 32'(halted), 32'd1);
    mach_code = W_ALU;
    for (int i = 0; i < 20; i++) begin
      #1;
      check($sformatf("halt_in_ready_%0d", i), 32'(in_ready), 32'd0);
      tick();
    end
    check("halt_after_outputs", 32'(obs), 32'(E_ZERO));
    check("halt_still", 32'(halted), 32'd1);
    Reset = 1'b0;
    tick();
    Reset = 1'b1; in_valid = 1'b0; #1;
    check("halt_reset_halted", 32'(halted), 32'd0);
    check("halt_reset_in_ready", 32'(in_ready), 32'd1);

    // Reset during the load-use bubble
    mach_code = W_LDR; in_valid = 1'b1;
    tick();
    check("rst_ldr_out", 32'(obs), 32'(e_ldr));
    mach_code = W_DEP; Reset = 1'b0; #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("rst_mid_outputs", 32'(obs), 32'(E_ZERO));
    Reset = 1'b1; #1;
    check("rst_no_stall", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("rst_dep_out", 32'(obs), 32'(e_dep));
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction decode stage for the 9-bit core. Accepts one machine word per cycle over a valid/ready handshake and presents registered control signals (`Aluop`, `Ra`, `Rb`, `Wd`, `WenR`, `WenD`, `Ldr`, `Str`, `Jump`, `Jptr`, `Halt`) to the execute stage. Adds load-use stall insertion and a sticky halt state. Sits between instruction fetch and the register file / ALU.

## Interface

Parameters:
- `JW`, 8: width of `Jptr`; must be ≥ 5; the 5-bit jump field is zero-extended.
- `LU_STALL`, 1: bubble cycles inserted on a load-use hazard; range 0..3.

Ports:
- `Clk` in 1: clock; all state updates on the rising edge.
- `Reset` in 1: synchronous, active-low reset.
- `in_valid` in 1: `mach_code` valid.
- `in_ready` out 1: stage accepts `mach_code` this cycle.
- `mach_code` in 9: instruction word.
- `out_valid` out 1: control outputs valid.
- `out_ready` in 1: execute stage consumes outputs this cycle.
- `Aluop` out 3, `Ra` out 3, `Rb` out 3, `Wd` out 3: ALU op, source A, source B, destination.
- `WenR`, `WenD`, `Ldr`, `Str`, `Jump`, `Halt` out 1 each: control strobes.
- `Jptr` out `JW`: jump LUT index.
- `halted` out 1: stage is in HALTED.

## Operation

Decode (`op = mach_code[8:6]`):
- `op` 000–100, ALU: `Aluop=op`, `Ra=Wd=[5:3]`, `Rb=[2:0]`, `WenR=1`; reads Ra, Rb.
- `op` 101, LDR: `Wd=[5:3]`, `Rb=[2:0]`, `Ldr=1`, `WenR=1`, `Aluop=000`; reads Rb.
- `op` 110, STR: `Ra=[5:3]` (data), `Rb=[2:0]` (address), `Str=1`, `WenD=1`; reads Ra, Rb.
- `op` 111 with `[5]=0`, JUMP: `Jump=1`, `Jptr={0,[4:0]}`; reads none.
- `mach_code=9'h1FF`: HALT, `Halt=1`.
- Other `op` 111 words: NOP, all strobes 0.
- Every field not listed is driven 0.

State machine (`RUN`, `HALTED`):
- RUN → HALTED when a HALT word is accepted.
- HALTED holds until reset. `in_ready=0`. The HALT output word still completes its handshake. `halted=1` from the cycle after acceptance.

Load-use hazard:
- Accepting an LDR loads `ld_reg=Wd` and `cnt=LU_STALL`.
- `cnt` decrements by one each cycle while it is greater than 0.
- If `cnt>0` and the presented word reads `ld_reg`, then `in_ready=0`.
- Accepting any non-LDR word clears `cnt`.
- Hazards are checked only against the immediately preceding accepted LDR.

Output register:
- `in_ready = Reset & RUN & (!out_valid | out_ready) & !stall`.
- Accept when `in_valid & in_ready`. Outputs load the decoded word and `out_valid=1`.
- When `out_valid & out_ready` and nothing is accepted, `out_valid=0` and all control outputs return to 0 (bubble).
- When `out_valid & !out_ready`, all outputs hold stable.

## Timing

- Latency: word accepted in cycle N is presented with `out_valid=1` in cycle N+1.
- Throughput: one word per cycle without hazards or backpressure.
- A load-use hazard costs exactly `LU_STALL` cycles with `out_ready=1`. Execute sees LDR, then `LU_STALL` bubbles, then the dependent word.
- Accept and drain in the same cycle is allowed (pass-through).
- Reset (`Reset=0` at an edge): `out_valid=0`, every control output 0, `Jptr=0`, `cnt=0`, state RUN, `halted=0`. `in_ready=0` while `Reset=0`.
- Reset wins over every simultaneous event, including mid-stall and in HALTED.
- `LU_STALL=0`: no stalls are ever inserted.

## Configuration

- `DECODE_HAZARD_EN` defined: load-use stall logic as described above.
- `DECODE_HAZARD_EN` undefined: the hazard tracker is removed and `stall` is tied 0. `LU_STALL` is ignored. Dependent words are accepted back-to-back; software must schedule the delay itself.

## Test plan

- ALU decode: `9'b001_010_011` accepted with `out_ready=1` → next cycle `Aluop=001`, `Ra=Wd=2`, `Rb=3`, `WenR=1`, other strobes 0.
- Load-use (macro on, `LU_STALL=1`): `9'b101_100_001` then `9'b000_100_010` → `in_ready=0` for exactly 1 cycle. Output sequence: LDR (`Ldr=1`, `Wd=4`), bubble, ALU (`Ra=4`). With the macro off: no bubble.
- Jump: `9'b111_0_10101` → `Jump=1`, `Jptr=8'd21`, `WenR=WenD=0`.
- Backpressure: hold `out_ready=0` for 5 cycles after an STR `9'b110_011_101` → outputs stable (`Str=1`, `WenD=1`, `Ra=3`, `Rb=5`), `in_ready=0`. Release → drains in 1 cycle.
- Halt: `9'h1FF` → `Halt=1` for one transfer, `halted=1`. `in_ready=0` for 20 cycles despite `in_valid=1`. `Reset=0` for one edge → `halted=0`, `in_ready=1`.
- Reset mid-stall: `Reset=0` during the LDR bubble → all outputs 0. After release, the dependent word is accepted with no stall.
